// File: rtl/traffic_light_controller.sv
// traffic_light_controller: T-junction signal controller with fixed cycle and emergency preemption
module traffic_light_controller #(
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 3,
  parameter int T_EM     = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Emergency_Left,
  input  logic       Emergency_Right,
  output logic [1:0] T1,
  output logic [1:0] T2,
  output logic       T1_WALK,
  output logic       T2_WALK,
  output logic       buzzer1,
  output logic       buzzer2
);
  typedef enum logic [2:0] {T1G, T1Y, T2G, T2Y, EM_L, EM_R} state_t;
  state_t state, next;
  logic [7:0] phase_cnt, em_cnt;
  logic normal, em_done;
  always_comb begin
    normal  = state inside {T1G, T1Y, T2G, T2Y};
    em_done = em_cnt >= 8'(T_EM - 1);
    next    = state;
    if (Emergency_Right && state != EM_R) next = EM_R;
    else if (Emergency_Left && normal) next = EM_L;
    else begin
      case (state)
        T1G:     next = phase_cnt == 8'(T_GREEN - 1)  ? T1Y : T1G;
        T1Y:     next = phase_cnt == 8'(T_YELLOW - 1) ? T2G : T1Y;
        T2G:     next = phase_cnt == 8'(T_GREEN - 1)  ? T2Y : T2G;
        T2Y:     next = phase_cnt == 8'(T_YELLOW - 1) ? T1G : T2Y;
        EM_R:    next = em_done && !Emergency_Right ? (Emergency_Left ? EM_L : T1G) : EM_R;
        EM_L:    next = em_done && !Emergency_Left ? T1G : EM_L;
        default: next = T1G;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= T1G;
      phase_cnt <= '0;
      em_cnt    <= '0;
    end else begin
      state     <= next;
      phase_cnt <= next != state ? '0 : phase_cnt + 8'd1;
      em_cnt    <= next != state ? '0 : em_cnt + {7'd0, em_cnt != 8'hff};
    end
  end
  always_comb begin
    T1      = state inside {T1G, EM_L} ? 2'b00 : state == T1Y ? 2'b01 : 2'b10;
    T2      = state inside {T2G, EM_R} ? 2'b00 : state == T2Y ? 2'b01 : 2'b10;
    T1_WALK = state == T2G;
    T2_WALK = state == T1G;
    buzzer1 = state == EM_L;
    buzzer2 = state == EM_R;
  end
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed scenario checks of lamp, walk and buzzer outputs per cycle
module tb_traffic_light_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic el = 1'b0;
  logic er = 1'b0;
  logic [1:0] t1, t2;
  logic t1_walk, t2_walk, buzzer1, buzzer2;
  logic [7:0] out;
  int checks = 0;
  int errors = 0;
  localparam logic [7:0] V_T1G = 8'b0010_0100;
  localparam logic [7:0] V_T1Y = 8'b0110_0000;
  localparam logic [7:0] V_T2G = 8'b1000_1000;
  localparam logic [7:0] V_T2Y = 8'b1001_0000;
  localparam logic [7:0] V_EML = 8'b0010_0010;
  localparam logic [7:0] V_EMR = 8'b1000_0001;
  traffic_light_controller dut (
    .clk(clk), .reset(reset), .Emergency_Left(el), .Emergency_Right(er),
    .T1(t1), .T2(t2), .T1_WALK(t1_walk), .T2_WALK(t2_walk),
    .buzzer1(buzzer1), .buzzer2(buzzer2)
  );
  always #5 clk = ~clk;
  assign out = {t1, t2, t1_walk, t2_walk, buzzer1, buzzer2};
  function automatic logic [7:0] exp_norm(input int c);
    int m;
    m = c % 46;
    return m < 20 ? V_T1G : m < 23 ? V_T1Y : m < 43 ? V_T2G : V_T2Y;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    el = 1'b0;
    er = 1'b0;
    tick;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    checks++;
    if (out !== V_T1G) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", out, V_T1G);
    end
    reset = 1'b1;
    el = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (out !== V_T1G) begin
      errors++;
      $display("FAIL reset_with_pending_left: got %b expected %b", out, V_T1G);
    end
    tick;
    checks++;
    if (out !== V_EML) begin
      errors++;
      $display("FAIL pending_left_after_reset: got %b expected %b", out, V_EML);
    end
    el = 1'b0;
  endtask
  task automatic test_normal_cycle;
    do_reset;
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (out !== exp_norm(c)) begin
        errors++;
        $display("FAIL normal_cycle c=%0d: got %b expected %b", c, out, exp_norm(c));
      end
      tick;
    end
  endtask
  task automatic test_left_pulse;
    logic [7:0] e;
    do_reset;
    for (int c = 0; c <= 62; c++) begin
      e = c <= 30 ? exp_norm(c) : c <= 39 ? V_EML : exp_norm(c - 40);
      checks++;
      if (out !== e) begin
        errors++;
        $display("FAIL left_pulse c=%0d: got %b expected %b", c, out, e);
      end
      if (c == 30) el = 1'b1;
      if (c == 32) el = 1'b0;
      tick;
    end
  endtask
  task automatic test_right_held;
    logic [7:0] e;
    do_reset;
    for (int c = 0; c <= 45; c++) begin
      e = c <= 5 ? exp_norm(c) : c <= 20 ? V_EMR : exp_norm(c - 21);
      checks++;
      if (out !== e) begin
        errors++;
        $display("FAIL right_held c=%0d: got %b expected %b", c, out, e);
      end
      if (c == 5) er = 1'b1;
      if (c == 20) er = 1'b0;
      tick;
    end
  endtask
  task automatic test_both_requests;
    logic [7:0] e;
    do_reset;
    for (int c = 0; c <= 50; c++) begin
      e = c <= 3 ? exp_norm(c) : c <= 18 ? V_EMR : c <= 27 ? V_EML : exp_norm(c - 28);
      checks++;
      if (out !== e || (buzzer1 && buzzer2)) begin
        errors++;
        $display("FAIL both_requests c=%0d: got %b expected %b", c, out, e);
      end
      if (c == 3) begin
        el = 1'b1;
        er = 1'b1;
      end
      if (c == 18) er = 1'b0;
      if (c == 23) el = 1'b0;
      tick;
    end
  endtask
  task automatic test_left_then_right;
    logic [7:0] e;
    do_reset;
    for (int c = 0; c <= 30; c++) begin
      e = c <= 2 ? exp_norm(c) : c <= 7 ? V_EML : c <= 16 ? V_EMR : c <= 25 ? V_EML : exp_norm(c - 26);
      checks++;
      if (out !== e) begin
        errors++;
        $display("FAIL left_then_right c=%0d: got %b expected %b", c, out, e);
      end
      if (c == 2) el = 1'b1;
      if (c == 7) er = 1'b1;
      if (c == 11) er = 1'b0;
      if (c == 20) el = 1'b0;
      tick;
    end
  endtask
  task automatic test_right_then_left;
    logic [7:0] e;
    do_reset;
    for (int c = 0; c <= 25; c++) begin
      e = c <= 2 ? exp_norm(c) : c <= 11 ? V_EMR : c <= 20 ? V_EML : exp_norm(c - 21);
      checks++;
      if (out !== e) begin
        errors++;
        $display("FAIL right_then_left c=%0d: got %b expected %b", c, out, e);
      end
      if (c == 2) er = 1'b1;
      if (c == 4) el = 1'b1;
      if (c == 6) er = 1'b0;
      if (c == 15) el = 1'b0;
      tick;
    end
  endtask
  task automatic test_back_to_back_reset;
    logic [7:0] e;
    do_reset;
    for (int c = 0; c <= 42; c++) begin
      e = c <= 1 ? exp_norm(c) : c <= 10 ? V_EMR : c <= 13 ? exp_norm(c - 11) : c <= 18 ? V_EML : exp_norm(c - 19);
      checks++;
      if (out !== e) begin
        errors++;
        $display("FAIL back_to_back_reset c=%0d: got %b expected %b", c, out, e);
      end
      if (c == 1) er = 1'b1;
      if (c == 6) er = 1'b0;
      if (c == 13) el = 1'b1;
      if (c == 18) begin
        el = 1'b0;
        reset = 1'b1;
      end
      if (c == 19) reset = 1'b0;
      tick;
    end
  endtask
  initial begin
    test_reset;
    test_normal_cycle;
    test_left_pulse;
    test_right_held;
    test_both_requests;
    test_left_then_right;
    test_right_then_left;
    test_back_to_back_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
